// File: rtl/fibo_request_sequencer_if.sv
// Host request/response and calculator launch/completion signals for the
// Fibonacci request sequencer; the sequencer connects through the slave modport.
interface fibo_request_sequencer_if #(
    parameter int unsigned SIZE = 4
);
    logic            REQ_VALID;
    logic            REQ_READY;
    logic [SIZE-1:0] REQ_COUNT;
    logic            START;
    logic [SIZE-1:0] COUNT;
    logic            DONE;
    logic [SIZE-1:0] DATA;
    logic            RSP_VALID;
    logic            RSP_READY;
    logic [SIZE-1:0] RSP_DATA;
    logic [SIZE-1:0] RSP_COUNT;
    logic            RSP_ERR;
    logic            BUSY;
    logic [7:0]      TO_CNT;

    modport slave (
        input  REQ_VALID, REQ_COUNT, DONE, DATA, RSP_READY,
        output REQ_READY, START, COUNT, RSP_VALID, RSP_DATA, RSP_COUNT,
        output RSP_ERR, BUSY, TO_CNT
    );

    modport master (
        output REQ_VALID, REQ_COUNT, DONE, DATA, RSP_READY,
        input  REQ_READY, START, COUNT, RSP_VALID, RSP_DATA, RSP_COUNT,
        input  RSP_ERR, BUSY, TO_CNT
    );
endinterface

// File: rtl/fibo_request_sequencer.sv
// Queues term-count requests, launches one Fibonacci calculation at a time and
// returns the result (or a timeout error) on a valid/ready response channel.
module fibo_request_sequencer #(
    parameter int unsigned SIZE    = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    fibo_request_sequencer_if.slave  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESPOND
    } state_t;

    logic [SIZE-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     occ_q;
    logic [AW:0]     occ_d;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    state_t          state_q;
    logic [7:0]      timer_q;
    logic            start_q;
    logic [SIZE-1:0] count_q;
    logic            rsp_valid_q;
    logic [SIZE-1:0] rsp_data_q;
    logic [SIZE-1:0] rsp_count_q;
    logic            rsp_err_q;
    logic            busy_q;
    logic [7:0]      to_cnt_q;

    assign full  = (occ_q == (AW+1)'(DEPTH));
    assign empty = (occ_q == '0);
    assign push  = bus.REQ_VALID && bus.REQ_READY;
    // Pop only from IDLE; the entry written this edge is not visible until the next.
    assign pop   = (state_q == IDLE) && !empty;

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.REQ_COUNT;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            start_q     <= 1'b0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_count_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        count_q <= mem_q[rd_ptr_q];
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    start_q <= 1'b0;
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    timer_q <= timer_q + 8'd1;
                    // timer==0 is a guard cycle so a DONE left over from the previous run is dropped.
                    if ((timer_q != 8'd0) && bus.DONE) begin
                        rsp_data_q  <= bus.DATA;
                        rsp_err_q   <= 1'b0;
                        rsp_count_q <= count_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESPOND;
                    end else if (timer_q == 8'(TIMEOUT)) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_count_q <= count_q;
                        rsp_valid_q <= 1'b1;
                        if (to_cnt_q != 8'hFF) begin
                            to_cnt_q <= to_cnt_q + 8'd1;
                        end
                        state_q <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (bus.RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.REQ_READY = RST && !full;
    assign bus.START     = start_q;
    assign bus.COUNT     = count_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_DATA  = rsp_data_q;
    assign bus.RSP_COUNT = rsp_count_q;
    assign bus.RSP_ERR   = rsp_err_q;
    assign bus.BUSY      = busy_q;
    assign bus.TO_CNT    = to_cnt_q;
endmodule

// File: tb/tb_fibo_request_sequencer.sv
// Directed self-checking bench for fibo_request_sequencer with a small
// calculator model that answers with Fibonacci values after a fixed delay.
module tb_fibo_request_sequencer;
    localparam int unsigned SIZE = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    fibo_request_sequencer_if #(.SIZE(SIZE)) bus ();

    fibo_request_sequencer #(
        .SIZE(SIZE),
        .DEPTH(4),
        .TIMEOUT(10)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    int calc_delay = 6;
    bit calc_stall = 1'b0;
    bit stale_mode = 1'b0;
    int cd         = 0;
    int drop       = 0;
    logic [3:0] fib_tab [8] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13};

    // Calculator: clears DONE on START (or keeps a stale DONE two cycles in
    // stale mode), then raises DONE with fib(COUNT) calc_delay cycles later.
    initial begin
        bus.DONE = 1'b0;
        bus.DATA = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.START === 1'b1) begin
                if (stale_mode) begin
                    bus.DATA = 4'd15;
                    drop     = 2;
                end else begin
                    bus.DONE = 1'b0;
                end
                cd = calc_delay;
            end else begin
                if (drop > 0) begin
                    drop--;
                    if (drop == 0) bus.DONE = 1'b0;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0 && !calc_stall) begin
                        bus.DONE = 1'b1;
                        bus.DATA = fib_tab[bus.COUNT[2:0]];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.RSP_VALID !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_COUNT = 4'd9;
        bus.RSP_READY = 1'b0;
        repeat (3) tick();
        checks++; if (bus.REQ_READY !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0b exp 0", bus.REQ_READY); end
        checks++; if (bus.START !== 1'b0) begin errors++; $display("FAIL rst_start got %0b exp 0", bus.START); end
        checks++; if (bus.RSP_VALID !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0b exp 0", bus.RSP_VALID); end
        checks++; if (bus.TO_CNT !== 8'd0) begin errors++; $display("FAIL rst_to_cnt got %0d exp 0", bus.TO_CNT); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", bus.BUSY); end
        RST = 1'b1;
        bus.REQ_VALID = 1'b0;
        tick();
        checks++; if (bus.REQ_READY !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %0b exp 1", bus.REQ_READY); end
        begin
            int starts = 0;
            repeat (4) begin
                tick();
                if (bus.START === 1'b1) starts++;
            end
            checks++; if (starts != 0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_no_push got starts=%0d busy=%0b exp starts=0 busy=0", starts, bus.BUSY); end
        end
    endtask

    task automatic test_single();
        int n;
        int starts = 0;
        checks++; if (bus.REQ_READY !== 1'b1) begin errors++; $display("FAIL single_ready got %0b exp 1", bus.REQ_READY); end
        bus.REQ_VALID = 1'b1;
        bus.REQ_COUNT = 4'd5;
        tick();
        bus.REQ_VALID = 1'b0;
        checks++; if (bus.START !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %0b exp 0", bus.START); end
        tick();
        checks++; if (bus.START !== 1'b1) begin errors++; $display("FAIL single_start got %0b exp 1", bus.START); end
        checks++; if (bus.COUNT !== 4'd5) begin errors++; $display("FAIL single_count got %0d exp 5", bus.COUNT); end
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL single_busy got %0b exp 1", bus.BUSY); end
        tick();
        checks++; if (bus.START !== 1'b0) begin errors++; $display("FAIL single_start_width got %0b exp 0", bus.START); end
        n = 0;
        while (bus.RSP_VALID !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (bus.START === 1'b1) starts++;
        end
        checks++; if (n != 6) begin errors++; $display("FAIL single_latency got %0d exp 6", n); end
        checks++; if (starts != 0) begin errors++; $display("FAIL single_extra_start got %0d exp 0", starts); end
        checks++; if (bus.RSP_DATA !== 4'd5) begin errors++; $display("FAIL single_data got %0d exp 5", bus.RSP_DATA); end
        checks++; if (bus.RSP_COUNT !== 4'd5) begin errors++; $display("FAIL single_rsp_count got %0d exp 5", bus.RSP_COUNT); end
        checks++; if (bus.RSP_ERR !== 1'b0) begin errors++; $display("FAIL single_err got %0b exp 0", bus.RSP_ERR); end
        repeat (2) tick();
        checks++; if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 4'd5) begin errors++; $display("FAIL single_hold got valid=%0b data=%0d exp valid=1 data=5", bus.RSP_VALID, bus.RSP_DATA); end
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
        checks++; if (bus.RSP_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL single_release got valid=%0b busy=%0b exp 0 0", bus.RSP_VALID, bus.BUSY); end
    endtask

    task automatic test_fill();
        logic [3:0] vals [5] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        int n;
        int starts = 0;
        bus.RSP_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.REQ_READY !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %0b exp 1", i, bus.REQ_READY); end
            bus.REQ_VALID = 1'b1;
            bus.REQ_COUNT = vals[i];
            tick();
        end
        bus.REQ_COUNT = 4'd8;
        checks++; if (bus.REQ_READY !== 1'b0) begin errors++; $display("FAIL fill_full got %0b exp 0", bus.REQ_READY); end
        repeat (2) tick();
        checks++; if (bus.REQ_READY !== 1'b0) begin errors++; $display("FAIL fill_full_hold got %0b exp 0", bus.REQ_READY); end
        bus.REQ_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(n);
            checks++; if (n >= 40) begin errors++; $display("FAIL fill_wait_%0d got timeout exp response", i); end
            checks++; if (bus.RSP_COUNT !== vals[i] || bus.RSP_DATA !== fib_tab[vals[i][2:0]] || bus.RSP_ERR !== 1'b0) begin
                errors++;
                $display("FAIL fill_rsp_%0d got count=%0d data=%0d err=%0b exp count=%0d data=%0d err=0",
                         i, bus.RSP_COUNT, bus.RSP_DATA, bus.RSP_ERR, vals[i], fib_tab[vals[i][2:0]]);
            end
            bus.RSP_READY = 1'b1;
            tick();
            bus.RSP_READY = 1'b0;
            if (i == 0) begin
                checks++; if (bus.REQ_READY !== 1'b0) begin errors++; $display("FAIL fill_no_early_pop got %0b exp 0", bus.REQ_READY); end
                tick();
                checks++; if (bus.REQ_READY !== 1'b1) begin errors++; $display("FAIL fill_pop_frees got %0b exp 1", bus.REQ_READY); end
            end
        end
        repeat (20) begin
            tick();
            if (bus.START === 1'b1) starts++;
        end
        checks++; if (starts != 0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL fill_drain got starts=%0d busy=%0b exp 0 0", starts, bus.BUSY); end
    endtask

    task automatic test_timeout();
        int n;
        calc_stall = 1'b1;
        bus.REQ_VALID = 1'b1;
        bus.REQ_COUNT = 4'd2;
        tick();
        bus.REQ_VALID = 1'b0;
        n = 0;
        while (bus.START !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++; if (n != 1) begin errors++; $display("FAIL to_start got %0d exp 1", n); end
        wait_rsp(n);
        checks++; if (n != 12) begin errors++; $display("FAIL to_latency got %0d exp 12", n); end
        checks++; if (bus.RSP_ERR !== 1'b1 || bus.RSP_DATA !== 4'd0) begin errors++; $display("FAIL to_rsp got err=%0b data=%0d exp err=1 data=0", bus.RSP_ERR, bus.RSP_DATA); end
        checks++; if (bus.RSP_COUNT !== 4'd2) begin errors++; $display("FAIL to_count got %0d exp 2", bus.RSP_COUNT); end
        checks++; if (bus.TO_CNT !== 8'd1) begin errors++; $display("FAIL to_cnt got %0d exp 1", bus.TO_CNT); end
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
        calc_stall = 1'b0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_COUNT = 4'd4;
        tick();
        bus.REQ_VALID = 1'b0;
        wait_rsp(n);
        checks++; if (n != 8 || bus.RSP_DATA !== 4'd3 || bus.RSP_ERR !== 1'b0) begin errors++; $display("FAIL to_recover got n=%0d data=%0d err=%0b exp n=8 data=3 err=0", n, bus.RSP_DATA, bus.RSP_ERR); end
        checks++; if (bus.TO_CNT !== 8'd1) begin errors++; $display("FAIL to_cnt_keep got %0d exp 1", bus.TO_CNT); end
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
    endtask

    task automatic test_stale_done();
        int n;
        stale_mode = 1'b1;
        bus.REQ_VALID = 1'b1;
        bus.REQ_COUNT = 4'd6;
        tick();
        bus.REQ_VALID = 1'b0;
        wait_rsp(n);
        checks++; if (n != 8) begin errors++; $display("FAIL stale_latency got %0d exp 8", n); end
        checks++; if (bus.RSP_DATA !== 4'd8 || bus.RSP_COUNT !== 4'd6 || bus.RSP_ERR !== 1'b0) begin
            errors++;
            $display("FAIL stale_data got data=%0d count=%0d err=%0b exp data=8 count=6 err=0", bus.RSP_DATA, bus.RSP_COUNT, bus.RSP_ERR);
        end
        stale_mode = 1'b0;
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
    endtask

    task automatic test_reset_mid();
        int starts = 0;
        int rsps = 0;
        calc_stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.REQ_VALID = 1'b1;
            bus.REQ_COUNT = 4'(i);
            tick();
        end
        bus.REQ_VALID = 1'b0;
        repeat (2) tick();
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL mid_busy got %0b exp 1", bus.BUSY); end
        RST = 1'b0;
        tick();
        checks++; if (bus.BUSY !== 1'b0 || bus.START !== 1'b0 || bus.RSP_VALID !== 1'b0 || bus.REQ_READY !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got busy=%0b start=%0b rsp=%0b ready=%0b exp 0 0 0 0", bus.BUSY, bus.START, bus.RSP_VALID, bus.REQ_READY);
        end
        checks++; if (bus.TO_CNT !== 8'd0) begin errors++; $display("FAIL mid_to_cnt got %0d exp 0", bus.TO_CNT); end
        RST = 1'b1;
        calc_stall = 1'b0;
        tick();
        checks++; if (bus.BUSY !== 1'b0 || bus.REQ_READY !== 1'b1) begin errors++; $display("FAIL mid_after got busy=%0b ready=%0b exp 0 1", bus.BUSY, bus.REQ_READY); end
        repeat (20) begin
            tick();
            if (bus.START === 1'b1) starts++;
            if (bus.RSP_VALID === 1'b1) rsps++;
        end
        checks++; if (starts != 0 || rsps != 0) begin errors++; $display("FAIL mid_flushed got starts=%0d rsps=%0d exp 0 0", starts, rsps); end
    endtask

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_COUNT = '0;
        bus.RSP_READY = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_timeout();
        test_stale_done();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
